// File: rtl/pwm_cmp_ramp_ctrl_if.sv
// ---------------------------------------------------------------------------
// pwm_cmp_ramp_ctrl_if
// Byte-wide register write bus from the I2C register interface into the
// PWM compare ramp controller.
//   reg_addr  : register address (REGBITS wide)
//   reg_data  : 8-bit write data
//   reg_valid : one-cycle write strobe
// master drives the bus (register interface), slave receives it (controller).
// ---------------------------------------------------------------------------
interface pwm_cmp_ramp_ctrl_if #(
    parameter int REGBITS = 3
);
    logic [REGBITS-1:0] reg_addr;
    logic [7:0]         reg_data;
    logic               reg_valid;

    modport master (
        output reg_addr,
        output reg_data,
        output reg_valid
    );

    modport slave (
        input reg_addr,
        input reg_data,
        input reg_valid
    );
endinterface

// File: rtl/pwm_cmp_ramp_ctrl.sv
// ---------------------------------------------------------------------------
// pwm_cmp_ramp_ctrl
// Sits between the I2C register interface and the PWM compare input. Byte
// writes are assembled into a scratch value; a commit makes it the target,
// and cmp then moves toward the target only on PWM period boundaries, either
// as a rate-limited ramp (effective step counts per period) or as a single
// aligned jump.
//
// Ports:
//   clk          : system clock (PWM slow clock domain)
//   rst_n        : asynchronous active-low reset
//   bus          : register write bus (reg_addr / reg_data / reg_valid)
//   period_start : one-cycle strobe on the first cycle of each PWM period
//   cmp          : compare value driven to the PWM
//   target       : committed target
//   busy         : high while a ramp or jump is pending
//   update_pulse : one-cycle pulse on each cycle cmp changes
//   done         : one-cycle pulse on the cycle cmp reaches target
//
// Register map: 0/1/2 scratch bytes, 3 commit, 4/5 step bytes,
//               6 ctrl (bit0 jump mode, bit1 hold), 7 abort.
// ---------------------------------------------------------------------------
module pwm_cmp_ramp_ctrl #(
    parameter int               WIDTH     = 19,
    parameter int               REGBITS   = 3,
    parameter logic [WIDTH-1:0] RESET_CMP = WIDTH'(19'h50001)
) (
    input  logic                clk,
    input  logic                rst_n,
    pwm_cmp_ramp_ctrl_if.slave  bus,
    input  logic                period_start,
    output logic [WIDTH-1:0]    cmp,
    output logic [WIDTH-1:0]    target,
    output logic                busy,
    output logic                update_pulse,
    output logic                done
);

    localparam int DW = WIDTH + 1;

    typedef enum logic [1:0] {
        IDLE,
        RAMP,
        JUMP
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] scratch;
    logic [15:0]      step;
    logic [1:0]       ctrl;

    logic             wr_commit;
    logic             wr_abort;
    logic             advance;
    logic [DW-1:0]    eff_step;
    logic [DW-1:0]    diff;
    logic [WIDTH-1:0] ramp_cmp;
    logic [WIDTH-1:0] cmp_after;
    logic [WIDTH-1:0] target_after;

    assign wr_commit = bus.reg_valid && (bus.reg_addr == REGBITS'(3));
    assign wr_abort  = bus.reg_valid && (bus.reg_addr == REGBITS'(7));

    // An abort on a boundary cycle wins: cmp stays put and the target
    // snaps to it, so an abort never moves cmp.
    assign advance = period_start && !ctrl[1] && (state != IDLE) && !wr_abort;

    assign busy = (state != IDLE);

    // Candidate cmp value for this boundary. The difference is taken in
    // WIDTH+1 bits so full-scale moves neither wrap nor overshoot; when the
    // remaining distance fits in one step the target is loaded exactly.
    always_comb begin
        eff_step = (step == 16'h0000) ? DW'(1) : DW'(step);
        if (target >= cmp) begin
            diff = {1'b0, target} - {1'b0, cmp};
        end else begin
            diff = {1'b0, cmp} - {1'b0, target};
        end
        ramp_cmp = target;
        if ((state == RAMP) && (diff > eff_step)) begin
            if (target > cmp) begin
                ramp_cmp = cmp + eff_step[WIDTH-1:0];
            end else begin
                ramp_cmp = cmp - eff_step[WIDTH-1:0];
            end
        end
        cmp_after    = advance ? ramp_cmp : cmp;
        target_after = wr_commit ? scratch : (wr_abort ? cmp : target);
    end

    // Register file, compare/target update and FSM. On a commit coinciding
    // with a boundary the step is taken toward the old target, then the new
    // target decides whether anything is still pending; done only fires if
    // cmp actually lands on the target that is in force afterwards.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            cmp          <= RESET_CMP;
            target       <= RESET_CMP;
            scratch      <= RESET_CMP;
            step         <= 16'h0001;
            ctrl         <= 2'b00;
            update_pulse <= 1'b0;
            done         <= 1'b0;
        end else begin
            update_pulse <= advance;
            done         <= advance && (cmp_after == target_after);
            cmp          <= cmp_after;
            target       <= target_after;

            if (bus.reg_valid) begin
                case (bus.reg_addr)
                    REGBITS'(0): scratch[7:0]        <= bus.reg_data;
                    REGBITS'(1): scratch[15:8]       <= bus.reg_data;
                    REGBITS'(2): scratch[WIDTH-1:16] <= bus.reg_data[WIDTH-17:0];
                    REGBITS'(4): step[7:0]           <= bus.reg_data;
                    REGBITS'(5): step[15:8]          <= bus.reg_data;
                    REGBITS'(6): ctrl                <= bus.reg_data[1:0];
                    default: ;
                endcase
            end

            if (wr_abort) begin
                state <= IDLE;
            end else if (wr_commit) begin
                if (cmp_after == scratch) begin
                    state <= IDLE;
                end else if (ctrl[0]) begin
                    state <= JUMP;
                end else begin
                    state <= RAMP;
                end
            end else if (advance && (cmp_after == target)) begin
                state <= IDLE;
            end
        end
    end

endmodule

// File: doc/pwm_cmp_ramp_ctrl.md
Name: pwm_cmp_ramp_ctrl

Overview:
- Controller between the I2C register interface and the PWM compare input.
- Assembles byte-wide register writes into a compare target and applies it to the PWM only at PWM period boundaries.
- Each change is either a rate-limited ramp of STEP counts per period or a single aligned jump.
- Replaces the direct scratch/commit write of the compare value in the top level.

Parameters:
- WIDTH, 19, compare/PWM width in bits (17..24).
- REGBITS, 3, register address width.
- RESET_CMP, 19'h50001, reset value of cmp, target and scratch.

Ports:
- clk  in  1  system clock (PWM slow clock domain).
- rst_n  in  1  asynchronous active-low reset.
- reg_addr  in  REGBITS  register address from the I2C register interface.
- reg_data  in  8  write data.
- reg_valid  in  1  one-cycle write strobe.
- period_start  in  1  one-cycle strobe from the PWM on the first cycle of each period.
- cmp  out  WIDTH  compare value driven to the PWM.
- target  out  WIDTH  committed target.
- busy  out  1  high while state != IDLE.
- update_pulse  out  1  one-cycle pulse on each cycle cmp changes.
- done  out  1  one-cycle pulse on the cycle cmp reaches target.

Behaviour:
- Reset (async, rst_n=0) values:
  - cmp = target = scratch = RESET_CMP; step = 16'h0001; ctrl = 0; state = IDLE.
  - busy = update_pulse = done = 0.
- Register map (writes only, on reg_valid):
  - 0: scratch[7:0].
  - 1: scratch[15:8].
  - 2: scratch[WIDTH-1:16], taking the low WIDTH-16 bits of reg_data.
  - 3: commit; target <= scratch, data ignored.
  - 4: step[7:0].
  - 5: step[15:8].
  - 6: ctrl. bit0 = jump mode, bit1 = hold (freeze ramp).
  - 7: abort; target <= cmp, data ignored.
- All register updates take effect the cycle after reg_valid.
- Effective step = (step==0) ? 1 : step, zero-extended to WIDTH.
- States:
  - IDLE: cmp == target.
  - RAMP: stepping toward target.
  - JUMP: waiting for a boundary to load target.
- Transitions:
  - On commit with scratch != cmp: ctrl.bit0 sampled at the commit cycle selects JUMP (1) or RAMP (0).
  - Commit with scratch == cmp: stays/returns IDLE, no done pulse.
- RAMP, on period_start with hold = 0:
  - diff = |target - cmp|, computed in WIDTH+1 bits.
  - If diff <= effective step: cmp <= target, done = 1, next state IDLE.
  - Otherwise cmp <= cmp ± effective step, toward target.
  - update_pulse = 1 in both cases.
  - No overshoot and no wrap; full-scale 0 to 2^WIDTH-1 is legal.
- JUMP, on period_start with hold = 0: cmp <= target, update_pulse = 1, done = 1, next state IDLE.
- hold = 1: period_start is ignored; cmp is frozen; state is retained; registers are still writable.
- cmp changes only on a cycle where period_start = 1. No change ever occurs mid-period.
- Simultaneous commit/abort and period_start in the same cycle:
  - The step uses the old target.
  - The new target is loaded.
  - Next state = IDLE iff cmp_next == target_next, else RAMP/JUMP per mode.
  - done is suppressed if target_next != cmp_next.
- Commit while RAMP/JUMP: target is retargeted. The direction is recomputed from the next boundary. The mode is re-sampled.
- Abort: target = current cmp; next state IDLE; no done pulse, no cmp change.
- Writes to addresses 0–2 and 4–6 never move cmp or change state.
- Asserting rst_n mid-ramp restores all reset values asynchronously. There is no ramp resume after reset.
- Latency: from the commit cycle to the first cmp change is the first period_start at least 1 cycle after the commit.

Test Plan:
- Reset, then idle 10 cycles with period_start pulsing -> cmp = 0x50001, busy = 0, no update_pulse.
- Write 0:0x00, 1:0x00, 2:0x06, commit, step = 0x4000, ramp mode -> target = 0x60000. cmp per period_start: 0x54001, 0x58001, 0x5C001, 0x60000. done pulses with the last step; busy then drops.
- Jump mode, commit 0x00010 -> cmp holds 0x50001 until the next period_start, then becomes 0x00010 in one step; update_pulse and done asserted in that single cycle.
- Ramp with step = 0 from 0x00005 to 0x00008 -> three periods of +1, then done. Also full-scale 0x7FFFF to 0 with step 0xFFFF: no underflow, final cmp = 0.
- Commit on the same cycle as period_start mid-ramp, with hold toggled -> the step uses the old target; the next steps head to the new target; with hold = 1, cmp frozen across 3 periods; abort -> busy = 0, target = cmp.
- Assert rst_n low mid-ramp, asynchronously between clock edges -> immediately cmp = 0x50001, state IDLE, step = 1.
